// File: rtl/leaf_router_fifo.sv
// Leaf router for one GPU group: one GPU port and NUM_SPINES spine ports,
// each with an ingress FIFO of {dest_addr, data}. The GPU FIFO feeds the
// spine egresses by dest select bits. Local-group heads from every FIFO
// compete round-robin for the GPU egress. Remote-group spine flits are
// dropped and counted.
module leaf_router_fifo #(
  parameter int          DWIDTH     = 16,
  parameter int          FIFO_DEPTH = 8,
  parameter int          NUM_SPINES = 4,
  parameter logic [3:0]  GROUP_ID   = 4'b1000,
  parameter int          SSEL_W     = (NUM_SPINES > 1) ? $clog2(NUM_SPINES) : 1,
  parameter int          GW         = $clog2(NUM_SPINES + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DWIDTH-1:0]            gpu_in_data,
  input  logic                         gpu_in_valid,
  output logic                         gpu_in_ready,
  input  logic [5:0]                   gpu_dest_addr,
  output logic [DWIDTH-1:0]            gpu_out_data,
  output logic                         gpu_out_valid,
  input  logic                         gpu_out_ready,
  input  logic [NUM_SPINES*DWIDTH-1:0] spine_in_data,
  input  logic [NUM_SPINES-1:0]        spine_in_valid,
  output logic [NUM_SPINES-1:0]        spine_in_ready,
  input  logic [NUM_SPINES*6-1:0]      spine_dest_addr,
  output logic [NUM_SPINES*DWIDTH-1:0] spine_out_data,
  output logic [NUM_SPINES-1:0]        spine_out_valid,
  input  logic [NUM_SPINES-1:0]        spine_out_ready,
  output logic [NUM_SPINES-1:0]        spine_fifo_full,
  output logic [NUM_SPINES-1:0]        spine_fifo_empty,
  output logic                         gpu_fifo_full,
  output logic                         gpu_fifo_empty,
  output logic [7:0]                   drop_count,
  output logic                         crossbar_busy,
  output logic [GW-1:0]                current_grant
);

  // FIFO index NUM_SPINES is the GPU ingress; indices below are spines.
  localparam int NF      = NUM_SPINES + 1;
  localparam int GPU_IDX = NUM_SPINES;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int EW      = DWIDTH + 6;

  // FIFO state
  logic [EW-1:0] mem_q      [NF][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q   [NF];
  logic [AW-1:0] wr_ptr_d   [NF];
  logic [AW-1:0] rd_ptr_q   [NF];
  logic [AW-1:0] rd_ptr_d   [NF];
  logic [CW-1:0] count_q    [NF];
  logic [CW-1:0] count_d    [NF];

  // Egress and arbiter state
  logic [DWIDTH-1:0]     gpu_out_data_q, gpu_out_data_d;
  logic                  gpu_out_valid_q, gpu_out_valid_d;
  logic [DWIDTH-1:0]     spine_out_data_q [NUM_SPINES];
  logic [DWIDTH-1:0]     spine_out_data_d [NUM_SPINES];
  logic [NUM_SPINES-1:0] spine_out_valid_q, spine_out_valid_d;
  logic [GW-1:0]         rr_q, rr_d;
  logic [GW-1:0]         current_grant_q, current_grant_d;
  logic [7:0]            drop_count_q, drop_count_d;

  // Combinational datapath
  logic [NF-1:0]         in_valid, full, empty, push, pop, head_local, req;
  logic [EW-1:0]         in_entry [NF];
  logic [EW-1:0]         head     [NF];
  logic [NUM_SPINES-1:0] drop, spine_load_ok;
  logic                  gpu_load_ok, gpu_to_spine;
  logic [SSEL_W-1:0]     gpu_sel;
  logic                  grant_valid;
  logic [GW-1:0]         grant_idx;
  logic [GW:0]           arb_sum;
  logic [GW-1:0]         arb_idx;
  logic [8:0]            drop_sum;
  logic                  spine_sel_unused;

  // Gather ingress ports into FIFO-indexed entries and derive FIFO status.
  always_comb begin
    // NOTE: every signal gets a default at the top of an always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    spine_sel_unused = 1'b0;
    for (int f = 0; f < NF; f++) begin
      if (f < NUM_SPINES) begin
        in_valid[f] = spine_in_valid[f];
        in_entry[f] = {spine_dest_addr[f*6 +: 6], spine_in_data[f*DWIDTH +: DWIDTH]};
      end else begin
        in_valid[f] = gpu_in_valid;
        in_entry[f] = {gpu_dest_addr, gpu_in_data};
      end
      full[f]       = (count_q[f] == CW'(FIFO_DEPTH));
      empty[f]      = (count_q[f] == '0);
      push[f]       = in_valid[f] && !full[f];
      head[f]       = mem_q[f][rd_ptr_q[f]];
      head_local[f] = (head[f][EW-1 -: 4] == GROUP_ID);
      req[f]        = !empty[f] && head_local[f];
    end
    // Spine heads never use their select bits; only the group matters.
    for (int i = 0; i < NUM_SPINES; i++) begin
      spine_sel_unused = spine_sel_unused ^ (^head[i][DWIDTH +: 2]);
    end
  end

  // Routing decisions: drops, GPU-to-spine forwarding and the egress arbiter.
  always_comb begin
    gpu_load_ok   = !gpu_out_valid_q || gpu_out_ready;
    spine_load_ok = ~spine_out_valid_q | spine_out_ready;
    for (int i = 0; i < NUM_SPINES; i++) begin
      drop[i] = !empty[i] && !head_local[i];
    end
    gpu_sel      = (NUM_SPINES == 1) ? '0 : head[GPU_IDX][DWIDTH +: SSEL_W];
    // A remote GPU head waits in place until its spine stage can load.
    gpu_to_spine = !empty[GPU_IDX] && !head_local[GPU_IDX] && spine_load_ok[gpu_sel];

    // Round-robin search starting at the pointer; first requester wins.
    grant_valid = 1'b0;
    grant_idx   = '0;
    arb_sum     = '0;
    arb_idx     = '0;
    for (int k = 0; k < NF; k++) begin
      arb_sum = {1'b0, rr_q} + (GW+1)'(k);
      if (arb_sum >= (GW+1)'(NF)) arb_sum = arb_sum - (GW+1)'(NF);
      arb_idx = arb_sum[GW-1:0];
      if (gpu_load_ok && !grant_valid && req[arb_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = arb_idx;
      end
    end

    for (int f = 0; f < NUM_SPINES; f++) begin
      pop[f] = drop[f] || (grant_valid && grant_idx == GW'(f));
    end
    pop[GPU_IDX] = (grant_valid && grant_idx == GW'(GPU_IDX)) || gpu_to_spine;
  end

  // Next-state for FIFO pointers and occupancy; pointers wrap naturally.
  always_comb begin
    for (int f = 0; f < NF; f++) begin
      wr_ptr_d[f] = wr_ptr_q[f] + AW'(push[f]);
      rd_ptr_d[f] = rd_ptr_q[f] + AW'(pop[f]);
      count_d[f]  = count_q[f] + CW'(push[f]) - CW'(pop[f]);
    end
  end

  // Next-state for egress registers, arbiter pointer and drop counter.
  always_comb begin
    gpu_out_valid_d = gpu_out_valid_q;
    gpu_out_data_d  = gpu_out_data_q;
    if (gpu_load_ok) begin
      gpu_out_valid_d = grant_valid;
      if (grant_valid) gpu_out_data_d = head[grant_idx][DWIDTH-1:0];
    end
    rr_d            = rr_q;
    current_grant_d = current_grant_q;
    if (grant_valid) begin
      rr_d            = (grant_idx == GW'(GPU_IDX)) ? '0 : grant_idx + GW'(1);
      current_grant_d = grant_idx;
    end

    for (int s = 0; s < NUM_SPINES; s++) begin
      spine_out_valid_d[s] = spine_out_valid_q[s];
      spine_out_data_d[s]  = spine_out_data_q[s];
      if (spine_load_ok[s]) begin
        spine_out_valid_d[s] = gpu_to_spine && (gpu_sel == SSEL_W'(s));
        if (spine_out_valid_d[s]) spine_out_data_d[s] = head[GPU_IDX][DWIDTH-1:0];
      end
    end

    // Same-cycle drops add up before saturating at 255.
    drop_sum = {1'b0, drop_count_q};
    for (int i = 0; i < NUM_SPINES; i++) begin
      drop_sum = drop_sum + 9'(drop[i]);
    end
    drop_count_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; emptiness is
    // tracked by the counters, so stale entries are never read.
    for (int f = 0; f < NF; f++) begin
      if (push[f]) mem_q[f][wr_ptr_q[f]] <= in_entry[f];
    end
  end

  // Control and egress registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      for (int f = 0; f < NF; f++) begin
        wr_ptr_q[f] <= '0;
        rd_ptr_q[f] <= '0;
        count_q[f]  <= '0;
      end
      for (int s = 0; s < NUM_SPINES; s++) spine_out_data_q[s] <= '0;
      spine_out_valid_q <= '0;
      gpu_out_valid_q   <= 1'b0;
      gpu_out_data_q    <= '0;
      rr_q              <= '0;
      current_grant_q   <= '0;
      drop_count_q      <= '0;
    end else begin
      for (int f = 0; f < NF; f++) begin
        wr_ptr_q[f] <= wr_ptr_d[f];
        rd_ptr_q[f] <= rd_ptr_d[f];
        count_q[f]  <= count_d[f];
      end
      for (int s = 0; s < NUM_SPINES; s++) spine_out_data_q[s] <= spine_out_data_d[s];
      spine_out_valid_q <= spine_out_valid_d;
      gpu_out_valid_q   <= gpu_out_valid_d;
      gpu_out_data_q    <= gpu_out_data_d;
      rr_q              <= rr_d;
      current_grant_q   <= current_grant_d;
      drop_count_q      <= drop_count_d;
    end
  end

  // Drive output ports from registered state.
  always_comb begin
    for (int s = 0; s < NUM_SPINES; s++) begin
      spine_out_data[s*DWIDTH +: DWIDTH] = spine_out_data_q[s];
    end
  end

  assign spine_out_valid  = spine_out_valid_q;
  assign gpu_out_valid    = gpu_out_valid_q;
  assign gpu_out_data     = gpu_out_data_q;
  assign spine_in_ready   = ~full[NUM_SPINES-1:0];
  assign spine_fifo_full  = full[NUM_SPINES-1:0];
  assign spine_fifo_empty = empty[NUM_SPINES-1:0];
  assign gpu_in_ready     = !full[GPU_IDX];
  assign gpu_fifo_full    = full[GPU_IDX];
  assign gpu_fifo_empty   = empty[GPU_IDX];
  assign drop_count       = drop_count_q;
  assign current_grant    = current_grant_q;
  assign crossbar_busy    = !(&empty) || gpu_out_valid_q || (|spine_out_valid_q);

endmodule

// File: tb/tb_leaf_router_fifo.sv
// Self-checking bench for leaf_router_fifo: table-driven routing vectors,
// directed multi-cycle sequences, and a randomized run scored against
// per-source / per-destination ordered queues.
module tb_leaf_router_fifo;
  localparam int         DW    = 16;
  localparam int         NS    = 4;
  localparam int         GW    = 3;
  localparam logic [3:0] GROUP = 4'b1000;
  localparam int         QD    = 4096;

  logic            clk = 1'b0;
  logic            reset;
  logic [DW-1:0]   gpu_in_data;
  logic            gpu_in_valid, gpu_in_ready;
  logic [5:0]      gpu_dest_addr;
  logic [DW-1:0]   gpu_out_data;
  logic            gpu_out_valid, gpu_out_ready;
  logic [NS*DW-1:0] spine_in_data, spine_out_data;
  logic [NS-1:0]   spine_in_valid, spine_in_ready, spine_out_valid, spine_out_ready;
  logic [NS*6-1:0] spine_dest_addr;
  logic [NS-1:0]   spine_fifo_full, spine_fifo_empty;
  logic            gpu_fifo_full, gpu_fifo_empty, crossbar_busy;
  logic [7:0]      drop_count;
  logic [GW-1:0]   current_grant;

  always #5 clk = ~clk;

  leaf_router_fifo dut (
    .clk(clk), .reset(reset),
    .gpu_in_data(gpu_in_data), .gpu_in_valid(gpu_in_valid), .gpu_in_ready(gpu_in_ready),
    .gpu_dest_addr(gpu_dest_addr),
    .gpu_out_data(gpu_out_data), .gpu_out_valid(gpu_out_valid), .gpu_out_ready(gpu_out_ready),
    .spine_in_data(spine_in_data), .spine_in_valid(spine_in_valid), .spine_in_ready(spine_in_ready),
    .spine_dest_addr(spine_dest_addr),
    .spine_out_data(spine_out_data), .spine_out_valid(spine_out_valid), .spine_out_ready(spine_out_ready),
    .spine_fifo_full(spine_fifo_full), .spine_fifo_empty(spine_fifo_empty),
    .gpu_fifo_full(gpu_fifo_full), .gpu_fifo_empty(gpu_fifo_empty),
    .drop_count(drop_count), .crossbar_busy(crossbar_busy), .current_grant(current_grant)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected GPU-egress flits per source, spine-egress flits per spine.
  logic [DW-1:0] exp_g [NS+1][QD];
  int            g_wr [NS+1];
  int            g_rd [NS+1];
  logic [DW-1:0] exp_s [NS][QD];
  int            s_wr [NS];
  int            s_rd [NS];
  int            drops_model;
  bit            mon_en = 1'b0;
  bit            hold_gpu;
  logic [DW-1:0] hold_data;

  task automatic monitor();
    int s;
    int src;
    bit have;
    if (hold_gpu) begin
      check("gpu_hold_valid", gpu_out_valid, 1'b1);
      check("gpu_hold_data", gpu_out_data, hold_data);
    end
    hold_gpu  = gpu_out_valid && !gpu_out_ready;
    hold_data = gpu_out_data;
    if (gpu_in_valid && gpu_in_ready) begin
      if (gpu_dest_addr[5:2] == GROUP) begin
        exp_g[NS][g_wr[NS]] = gpu_in_data; g_wr[NS]++;
      end else begin
        s = int'(gpu_dest_addr[1:0]);
        exp_s[s][s_wr[s]] = gpu_in_data; s_wr[s]++;
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (spine_in_valid[i] && spine_in_ready[i]) begin
        if (spine_dest_addr[i*6+2 +: 4] == GROUP) begin
          exp_g[i][g_wr[i]] = spine_in_data[i*DW +: DW]; g_wr[i]++;
        end else begin
          drops_model++;
        end
      end
    end
    if (gpu_out_valid && gpu_out_ready) begin
      src  = int'(current_grant);
      have = (src <= NS) && (g_rd[src] != g_wr[src]);
      check("gpu_egress_expected", have, 1'b1);
      if (have) begin
        check("gpu_egress_data", gpu_out_data, exp_g[src][g_rd[src]]);
        g_rd[src]++;
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (spine_out_valid[i] && spine_out_ready[i]) begin
        have = (s_rd[i] != s_wr[i]);
        check("spine_egress_expected", have, 1'b1);
        if (have) begin
          check("spine_egress_data", spine_out_data[i*DW +: DW], exp_s[i][s_rd[i]]);
          s_rd[i]++;
        end
      end
    end
  endtask

  // Inputs change at posedge+1; outputs are sampled at negedge or posedge+1.
  task automatic tick();
    @(negedge clk);
    if (mon_en) monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    gpu_in_valid = 1'b0; gpu_in_data = '0; gpu_dest_addr = '0; gpu_out_ready = 1'b1;
    spine_in_valid = '0; spine_in_data = '0; spine_dest_addr = '0; spine_out_ready = '1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
  endtask

  typedef struct {
    logic [5:0]    addr;
    logic [DW-1:0] data;
    logic [NS-1:0] exp_sv;
    logic          exp_gv;
  } vec_t;

  vec_t vecs [6];
  int   got;

  initial begin
    vecs[0] = '{6'b0011_10, 16'hA5A5, 4'b0100, 1'b0};
    vecs[1] = '{6'b0000_00, 16'h1234, 4'b0001, 1'b0};
    vecs[2] = '{6'b0101_11, 16'hBEEF, 4'b1000, 1'b0};
    vecs[3] = '{6'b1111_01, 16'h0F0F, 4'b0010, 1'b0};
    vecs[4] = '{6'b1000_10, 16'hC0DE, 4'b0000, 1'b1};
    vecs[5] = '{6'b1001_01, 16'h5A5A, 4'b0010, 1'b0};

    // Reset with random inputs
    idle_inputs();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      gpu_in_valid = 1'($urandom); gpu_in_data = 16'($urandom); gpu_dest_addr = 6'($urandom);
      spine_in_valid = 4'($urandom); spine_in_data = {$urandom, $urandom};
      spine_dest_addr = 24'($urandom); spine_out_ready = 4'($urandom); gpu_out_ready = 1'($urandom);
      tick();
    end
    check("rst_gpu_out_valid", gpu_out_valid, 1'b0);
    check("rst_spine_out_valid", spine_out_valid, 4'b0000);
    check("rst_drop_count", drop_count, 8'd0);
    check("rst_current_grant", current_grant, 3'd0);
    check("rst_spine_in_ready", spine_in_ready, 4'b1111);
    check("rst_gpu_fifo_empty", gpu_fifo_empty, 1'b1);
    check("rst_spine_fifo_empty", spine_fifo_empty, 4'b1111);
    check("rst_gpu_in_ready", gpu_in_ready, 1'b1);
    check("rst_busy", crossbar_busy, 1'b0);
    idle_inputs();
    reset = 1'b1;

    // Table-driven single-flit routing from the GPU port
    for (int v = 0; v < 6; v++) begin
      gpu_in_valid = 1'b1; gpu_in_data = vecs[v].data; gpu_dest_addr = vecs[v].addr;
      check("vec_in_ready", gpu_in_ready, 1'b1);
      tick();
      gpu_in_valid = 1'b0;
      check("vec_lat1_spine", spine_out_valid, 4'b0000);
      check("vec_lat1_gpu", gpu_out_valid, 1'b0);
      tick();
      check("vec_spine_valid", spine_out_valid, vecs[v].exp_sv);
      check("vec_gpu_valid", gpu_out_valid, vecs[v].exp_gv);
      if (vecs[v].exp_gv) begin
        check("vec_gpu_data", gpu_out_data, vecs[v].data);
        check("vec_gpu_grant", current_grant, 3'd4);
      end
      for (int s = 0; s < NS; s++) begin
        if (vecs[v].exp_sv[s]) check("vec_spine_data", spine_out_data[s*DW +: DW], vecs[v].data);
      end
      tick();
      check("vec_drained", {gpu_out_valid, spine_out_valid}, 5'b0);
    end

    // Fairness: four spines, two local flits each
    do_reset();
    spine_in_valid = '1;
    for (int i = 0; i < NS; i++) begin
      spine_dest_addr[i*6 +: 6] = {GROUP, 2'(i)};
      spine_in_data[i*DW +: DW] = 16'h1000 + 16'(i);
    end
    tick();
    for (int i = 0; i < NS; i++) spine_in_data[i*DW +: DW] = 16'h1100 + 16'(i);
    tick();
    spine_in_valid = '0;
    got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      if (gpu_out_valid) begin
        check("fair_data", gpu_out_data, 16'h1000 + 16'((got / 4) * 256 + (got % 4)));
        check("fair_grant", current_grant, 3'(got % 4));
        got++;
      end
      tick();
    end
    check("fair_count", got, 8);

    // Backpressure: spine 1 stalled, nine GPU flits
    do_reset();
    spine_out_ready = 4'b1101;
    for (int k = 0; k < 9; k++) begin
      gpu_in_valid = 1'b1; gpu_dest_addr = 6'b0000_01; gpu_in_data = 16'hB000 + 16'(k);
      check("bp_ready_before_full", gpu_in_ready, 1'b1);
      tick();
    end
    gpu_in_valid = 1'b0;
    check("bp_ready_low", gpu_in_ready, 1'b0);
    check("bp_fifo_full", gpu_fifo_full, 1'b1);
    check("bp_spine_valid", spine_out_valid, 4'b0010);
    check("bp_spine1_data", spine_out_data[1*DW +: DW], 16'hB000);
    tick();
    check("bp_hold_valid", spine_out_valid, 4'b0010);
    check("bp_hold_data", spine_out_data[1*DW +: DW], 16'hB000);
    spine_out_ready = '1;
    got = 0;
    for (int c = 0; c < 40 && got < 9; c++) begin
      if (spine_out_valid[1]) begin
        check("bp_order", spine_out_data[1*DW +: DW], 16'hB000 + 16'(got));
        got++;
      end
      tick();
    end
    check("bp_count", got, 9);
    check("bp_fifo_empty", gpu_fifo_empty, 1'b1);

    // Drop saturation: spine 3 sends 300 remote flits
    do_reset();
    spine_in_valid = 4'b1000;
    spine_dest_addr[3*6 +: 6] = 6'b0001_00;
    got = 0;
    for (int n = 0; n < 300; n++) begin
      spine_in_data[3*DW +: DW] = 16'(n);
      tick();
      if (gpu_out_valid) got++;
      if (n == 199) check("drop_count_mid", drop_count, 8'd199);
    end
    spine_in_valid = '0;
    tick();
    check("drop_count_sat", drop_count, 8'd255);
    check("drop_no_gpu_out", got, 0);
    check("drop_fifos_empty", spine_fifo_empty, 4'b1111);

    // Mid-operation reset with flits buffered and egress stalled
    gpu_out_ready = 1'b0;
    spine_in_valid = 4'b0001;
    spine_dest_addr[0 +: 6] = {GROUP, 2'b00};
    for (int k = 0; k < 6; k++) begin
      spine_in_data[0 +: DW] = 16'hD000 + 16'(k);
      tick();
    end
    spine_in_valid = '0;
    check("mid_pre_gpu_valid", gpu_out_valid, 1'b1);
    check("mid_pre_fifo0_empty", spine_fifo_empty[0], 1'b0);
    reset = 1'b0;
    tick();
    check("mid_gpu_valid", gpu_out_valid, 1'b0);
    check("mid_spine_empty", spine_fifo_empty, 4'b1111);
    check("mid_gpu_empty", gpu_fifo_empty, 1'b1);
    check("mid_drop_count", drop_count, 8'd0);
    check("mid_busy", crossbar_busy, 1'b0);
    reset = 1'b1;
    gpu_out_ready = 1'b1;
    gpu_in_valid = 1'b1; gpu_dest_addr = {GROUP, 2'b00}; gpu_in_data = 16'hE00E;
    tick();
    gpu_in_valid = 1'b0;
    check("post_lat1", gpu_out_valid, 1'b0);
    tick();
    check("post_valid", gpu_out_valid, 1'b1);
    check("post_data", gpu_out_data, 16'hE00E);
    check("post_grant", current_grant, 3'd4);
    tick();
    check("post_no_stale", gpu_out_valid, 1'b0);

    // Randomized traffic against the ordered-queue model
    do_reset();
    for (int i = 0; i <= NS; i++) begin g_wr[i] = 0; g_rd[i] = 0; end
    for (int i = 0; i < NS; i++) begin s_wr[i] = 0; s_rd[i] = 0; end
    drops_model = 0;
    hold_gpu = 1'b0;
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      gpu_in_valid  = ($urandom_range(0, 9) < 6);
      gpu_in_data   = 16'($urandom);
      gpu_dest_addr = {($urandom_range(0, 1) == 0) ? GROUP : 4'($urandom_range(0, 7)),
                       2'($urandom)};
      gpu_out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NS; i++) begin
        spine_in_valid[i]         = ($urandom_range(0, 9) < 6);
        spine_in_data[i*DW +: DW] = 16'($urandom);
        spine_dest_addr[i*6 +: 6] = {($urandom_range(0, 63) == 0) ? 4'($urandom_range(0, 7)) : GROUP,
                                     2'($urandom)};
        spine_out_ready[i]        = ($urandom_range(0, 9) < 7);
      end
      tick();
    end
    gpu_in_valid = 1'b0; spine_in_valid = '0; gpu_out_ready = 1'b1; spine_out_ready = '1;
    for (int c = 0; c < 200; c++) tick();
    mon_en = 1'b0;
    for (int i = 0; i <= NS; i++) check("rand_gpu_queue_drained", g_wr[i] - g_rd[i], 0);
    for (int i = 0; i < NS; i++) check("rand_spine_queue_drained", s_wr[i] - s_rd[i], 0);
    check("rand_drop_count", drop_count, (drops_model > 255) ? 255 : drops_model);
    check("rand_idle", crossbar_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/leaf_router_fifo.md
Name: leaf_router_fifo

Overview:
Parametrised next-generation leaf router for one GPU group. It connects one GPU port to NUM_SPINES spine ports through per-input FIFOs, group-address routing, and a round-robin arbiter on the shared GPU egress. Every port uses a valid/ready handshake with registered outputs. FIFO status is live, not tied off.

Parameters:
DWIDTH, 16, flit data width
FIFO_DEPTH, 8, entries per input FIFO; power of 2, ≥2
NUM_SPINES, 4, spine port count; must be 1, 2 or 4
GROUP_ID, 4'b1000, this leaf's group; compared to dest_addr[5:2]
SSEL_W, derived = max(1,log2(NUM_SPINES)), spine-select bits
GW, derived = clog2(NUM_SPINES+1), grant index width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
gpu_in_data  in  DWIDTH  GPU ingress flit
gpu_in_valid  in  1  ingress valid
gpu_in_ready  out  1  = !gpu FIFO full
gpu_dest_addr  in  6  {group[3:0], sel[1:0]}
gpu_out_data  out  DWIDTH  GPU egress flit
gpu_out_valid  out  1  egress valid
gpu_out_ready  in  1  egress accept
spine_in_data  in  NUM_SPINES*DWIDTH  spine ingress, port i at [i*DWIDTH +: DWIDTH]
spine_in_valid  in  NUM_SPINES  per-spine valid
spine_in_ready  out  NUM_SPINES  = !spine FIFO i full
spine_dest_addr  in  NUM_SPINES*6  per-spine destination
spine_out_data  out  NUM_SPINES*DWIDTH  spine egress
spine_out_valid  out  NUM_SPINES  egress valid
spine_out_ready  in  NUM_SPINES  egress accept
spine_fifo_full / spine_fifo_empty  out  NUM_SPINES  ingress FIFO status
gpu_fifo_full / gpu_fifo_empty  out  1  GPU ingress FIFO status
drop_count  out  8  saturating count of dropped spine flits
crossbar_busy  out  1  any FIFO non-empty OR any out_valid
current_grant  out  GW  last GPU-egress grant index (NUM_SPINES = GPU loopback)

Behaviour:
- Reset (reset==0 at clk edge): all FIFOs emptied (ptrs/count 0). All *_out_valid=0, out data=0, drop_count=0, current_grant=0, RR pointer=0. Ready outputs = 1 and empty flags = 1 from the first cycle after reset. Reset mid-transfer discards all in-flight flits.
- FIFO: each stores {dest_addr,data}. Push when valid&&ready. A push into a full FIFO cannot occur (ready=0). Simultaneous push+pop on a full FIFO is not accepted: ready is derived from full only. Pointers wrap modulo FIFO_DEPTH.
- Output stage per egress: one register. It loads when (!out_valid || out_ready); otherwise it holds data and valid stable.
- Latency: flit accepted at edge N, output idle → out_valid high in the cycle after edge N+1 (2 cycles).
- GPU FIFO head, local (group==GROUP_ID): requests the GPU-egress arbiter (loopback, index NUM_SPINES).
- GPU FIFO head, remote: targets spine s = dest[SSEL_W-1:0] (s=0 when NUM_SPINES=1). It pops into spine_out[s] when that stage can load. It stalls otherwise (head-of-line blocking intended).
- Spine FIFO i head, local: requests arbiter index i.
- Spine FIFO i head, remote group: popped and discarded that cycle, and drop_count increments. Drop_count saturates at 255. Several same-cycle drops add their total and saturate.
- GPU-egress arbiter: round-robin over NUM_SPINES+1 requesters. A grant occurs only when the GPU output stage can load. Search starts at the RR pointer. After a grant to index g, pointer = (g+1) mod (NUM_SPINES+1) and current_grant = g. With no grant, pointer and current_grant hold. At most one grant per cycle.
- Spine egresses are fed only from the GPU FIFO, so at most one spine loads per cycle.

Test Plan:
- Reset: hold reset=0 for 3 cycles with random inputs → all out_valid=0, drop_count=0, current_grant=0, spine_in_ready=4'b1111, gpu_fifo_empty=1.
- GPU→spine: gpu_in data=16'hA5A5, dest=6'b0011_10 → spine_out_valid=4'b0100 two cycles later, spine 2 data=16'hA5A5; no other valid.
- Fairness: spines 0–3 each push 2 flits with dest group 4'b1000, gpu_out_ready=1 → GPU egress order: spine0,1,2,3,0,1,2,3; current_grant sequence 0,1,2,3,0,1,2,3.
- Backpressure/full: spine_out_ready[1]=0, push 9 GPU flits dest=6'b0000_01 → spine 1 register holds flit 1; gpu_in_ready drops after 8 more are accepted (FIFO full). Release ready → all 9 flits delivered in order.
- Drop: spine 3 pushes 300 flits dest group 4'b0001 → no gpu_out_valid; drop_count saturates at 255.
- Mid-op reset: assert reset with 5 flits buffered and gpu_out_valid=1 → next cycle gpu_out_valid=0 and all FIFOs empty. A post-reset flit follows the 2-cycle latency.
